// File: rtl/sseg_share_arbiter.sv
// Purpose: round-robin sharing of one 4-digit seven-segment driver between N_REQ requesters, with a minimum dwell.
// Latency: 1 cycle from request/data to grant/disp_value; all outputs are registered.
// Backpressure: none; requests are levels, and a waiting requester is served at release or at dwell expiry.
module sseg_share_arbiter #(
  parameter int N_REQ = 3,
  parameter int DWELL = 50_000_000,
  parameter int CNT_W = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      grant,
  output logic [15:0]           disp_value,
  output logic [1:0]            disp_src,
  output logic                  busy
);

  // Every nibble above 9 is decoded as dark by the display driver.
  localparam logic [15:0]      BLANK     = 16'hFFFF;
  localparam logic [2:0]       NR3       = 3'(N_REQ);
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL - 1);

  // One-hot encoding, so any other code is recognisably illegal and falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b01,
    OWN  = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       rr_ptr;
  logic [1:0]       rr_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [15:0]      disp_value_nxt;
  logic [1:0]       disp_src_nxt;
  logic             busy_nxt;

  // While a grant is active, disp_src holds the owner index, so it doubles as the owner register.
  logic             owner_req;
  logic [N_REQ-1:0] others;
  logic [2:0]       inc3;
  logic [1:0]       owner_inc;
  logic [1:0]       idle_win;
  logic [1:0]       pre_win;
  logic             dwell_done;

  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    onehot = '0;
    for (int i = 0; i < N_REQ; i++) onehot[i] = (idx == 2'(i));
  endfunction

  // An index outside the requester range selects the blank word.
  function automatic logic [15:0] slice_of(input logic [16*N_REQ-1:0] d, input logic [1:0] idx);
    slice_of = BLANK;
    for (int i = 0; i < N_REQ; i++) begin
      if (idx == 2'(i)) slice_of = d[16*i +: 16];
    end
  endfunction

  // Returns the first requester at or after base, or after base when skip0 is set, wrapping at N_REQ-1.
  // The request vector is rotated so that bit k is requester (base+k) mod N_REQ.
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [1:0] base,
                                         input logic skip0);
    logic [N_REQ-1:0] rot;
    logic [2:0]       idx;
    rr_pick = base;
    rot     = N_REQ'({r, r} >> base);
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k] && !(skip0 && (k == 0))) begin
        idx = {1'b0, base} + 3'(k);
        if (idx >= NR3) idx = idx - NR3;
        rr_pick = idx[1:0];
      end
    end
  endfunction

  // Arbitration helpers derived from the current owner, the pointer and the dwell counter.
  always_comb begin
    owner_req  = |(req & onehot(disp_src));
    others     = req & ~onehot(disp_src);
    inc3       = {1'b0, disp_src} + 3'd1;
    owner_inc  = (inc3 >= NR3) ? 2'd0 : inc3[1:0];
    dwell_done = (cnt == DWELL_MAX);
    idle_win   = rr_pick(req, rr_ptr, 1'b0);
    pre_win    = rr_pick(req, disp_src, 1'b1);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: a release always goes back to IDLE, and a preemption stays in OWN.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = (|req) ? OWN : IDLE;
      OWN:     state_nxt = owner_req ? OWN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, the dwell counter and the rr pointer.
  always_comb begin
    grant_nxt      = '0;
    disp_value_nxt = BLANK;
    disp_src_nxt   = disp_src;
    busy_nxt       = 1'b0;
    cnt_nxt        = '0;
    rr_nxt         = rr_ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt      = onehot(idle_win);
          disp_value_nxt = slice_of(req_data, idle_win);
          disp_src_nxt   = idle_win;
          busy_nxt       = 1'b1;
        end
      end
      OWN: begin
        if (!owner_req) begin
          // Release takes priority over dwell expiry; arbitration restarts from IDLE next cycle.
          rr_nxt = owner_inc;
        end else if (dwell_done && (|others)) begin
          // Hand over directly, so grant never passes through zero.
          grant_nxt      = onehot(pre_win);
          disp_value_nxt = slice_of(req_data, pre_win);
          disp_src_nxt   = pre_win;
          busy_nxt       = 1'b1;
          rr_nxt         = owner_inc;
        end else begin
          grant_nxt      = onehot(disp_src);
          disp_value_nxt = slice_of(req_data, disp_src);
          busy_nxt       = 1'b1;
          cnt_nxt        = dwell_done ? cnt : cnt + 1'b1;
        end
      end
      default: begin
        rr_nxt = '0;
      end
    endcase
  end

  // Registered outputs and arbitration bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      disp_value <= BLANK;
      disp_src   <= 2'd0;
      busy       <= 1'b0;
      cnt        <= '0;
      rr_ptr     <= 2'd0;
    end else begin
      grant      <= grant_nxt;
      disp_value <= disp_value_nxt;
      disp_src   <= disp_src_nxt;
      busy       <= busy_nxt;
      cnt        <= cnt_nxt;
      rr_ptr     <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_sseg_share_arbiter.sv
// Bench for sseg_share_arbiter with N_REQ=3 and DWELL=4.
// A behavioural ownership model is checked on every falling edge, and directed literal checks pin the model.
module tb_sseg_share_arbiter;

  localparam int N  = 3;
  localparam int DW = 4;

  logic              clk      = 1'b0;
  logic              rst      = 1'b1;
  logic [N-1:0]      req      = '0;
  logic [16*N-1:0]   req_data = '0;
  logic [N-1:0]      grant;
  logic [15:0]       disp_value;
  logic [1:0]        disp_src;
  logic              busy;

  int checks = 0;
  int fails  = 0;
  bit armed  = 1'b0;

  // Expected grant sequence for req=3'b101 starting from the reset pointer.
  logic [2:0] exp3 [12] = '{3'b001, 3'b001, 3'b001, 3'b001,
                            3'b100, 3'b100, 3'b100, 3'b100,
                            3'b001, 3'b001, 3'b001, 3'b001};

  sseg_share_arbiter #(.N_REQ(N), .DWELL(DW), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .disp_value (disp_value),
    .disp_src   (disp_src),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  // Behavioural model: owner index (-1 when idle), number of cycles the owner has been visible, next start index.
  int          m_owner = -1;
  int          m_held  = 0;
  int          m_rr    = 0;
  int          m_src   = 0;
  logic [15:0] m_val   = 16'hFFFF;

  function automatic logic [15:0] word(input int i);
    return req_data[16*i +: 16];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_held = 0; m_rr = 0; m_src = 0; m_val = 16'hFFFF;
    end else if (m_owner < 0) begin
      int pick;
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && req[(m_rr + k) % N]) pick = (m_rr + k) % N;
      if (pick >= 0) begin
        m_owner = pick; m_held = 1; m_src = pick; m_val = word(pick);
      end else begin
        m_val = 16'hFFFF;
      end
    end else if (!req[m_owner]) begin
      m_rr = (m_owner + 1) % N; m_owner = -1; m_val = 16'hFFFF;
    end else begin
      int nxt;
      nxt = -1;
      if (m_held >= DW)
        for (int k = 1; k < N; k++)
          if (nxt < 0 && req[(m_owner + k) % N]) nxt = (m_owner + k) % N;
      if (nxt >= 0) begin
        m_rr = (m_owner + 1) % N; m_owner = nxt; m_held = 1;
      end else begin
        m_held++;
      end
      m_src = m_owner; m_val = word(m_owner);
    end
  end

  // Compare the DUT against the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (armed && !rst) begin
      chk("m_grant",   grant,      (m_owner < 0) ? 0 : (1 << m_owner));
      chk("m_busy",    busy,       32'(m_owner >= 0));
      chk("m_value",   disp_value, m_val);
      chk("m_src",     disp_src,   m_src);
      chk("m_onehot0", 32'($onehot0(grant)), 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time budget expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    rst   = 1'b0;
    armed = 1'b1;
    cyc(1);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_value", disp_value, 16'hFFFF);
    chk("rst_src", disp_src, 0);

    // Single requester, then live data tracking, then release.
    req_data[31:16] = 16'h1234;
    req = 3'b010;
    cyc(1);
    chk("own1_grant", grant, 3'b010);
    chk("own1_value", disp_value, 16'h1234);
    chk("own1_src", disp_src, 1);
    req_data[31:16] = 16'h0042;
    cyc(1);
    chk("track_value", disp_value, 16'h0042);
    req = 3'b000;
    cyc(1);
    chk("rel_grant", grant, 0);
    chk("rel_value", disp_value, 16'hFFFF);
    chk("rel_src_hold", disp_src, 1);

    // Round-robin with dwell: two contenders alternate every DWELL cycles.
    pulse_reset();
    req_data = {16'h2222, 16'h0042, 16'h0111};
    req = 3'b101;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      chk("rr_seq", grant, exp3[i]);
      if (i == 5) req_data[15:0] = 16'h0777;
    end

    // Early release by owner 0 with requester 2 waiting: exactly one idle cycle.
    req = 3'b000;
    pulse_reset();
    req = 3'b101;
    cyc(2);
    chk("early_own0", grant, 3'b001);
    req = 3'b100;
    cyc(1);
    chk("gap_grant", grant, 0);
    chk("gap_value", disp_value, 16'hFFFF);
    cyc(1);
    chk("after_gap_grant", grant, 3'b100);
    chk("after_gap_value", disp_value, 16'h2222);

    // A lone owner keeps the display past the dwell; a late contender then preempts at once.
    req = 3'b000;
    cyc(1);
    req_data[31:16] = 16'h5678;
    req = 3'b010;
    cyc(10);
    chk("lone_hold", grant, 3'b010);
    chk("lone_value", disp_value, 16'h5678);
    req = 3'b011;
    cyc(1);
    chk("late_preempt", grant, 3'b001);
    chk("late_value", disp_value, 16'h0777);
    chk("late_src", disp_src, 0);

    // Asynchronous reset between edges, then requester 0 is served first.
    req = 3'b111;
    cyc(2);
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_value", disp_value, 16'hFFFF);
    chk("arst_busy", busy, 0);
    chk("arst_src", disp_src, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_grant", grant, 3'b001);
    chk("post_rst_value", disp_value, 16'h0777);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
